// File: rtl/sysbus_pkg.sv
// Shared definitions for the SPI hard-IP system bus bridge and the upstream subordinate FSM.
package sysbus_pkg;

    localparam int unsigned ADR_W = 8;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned TO_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [ADR_W-1:0] SPITXDR = 8'h59;
    localparam logic [ADR_W-1:0] SPIISR  = 8'h5A;
    localparam logic [ADR_W-1:0] SPIRXDR = 8'h5B;

    localparam int unsigned ISR_RRDY = 3;
    localparam int unsigned ISR_TRDY = 4;

    typedef struct packed {
        logic             rw;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } sb_req_t;

    localparam sb_req_t REQ_RST = '{rw: 1'b0, adr: SPITXDR, dat: '0};

    // A single-direction request to the in-flight address and direction is a retry, not a new cycle.
    function automatic logic is_hold(input sb_req_t cur, input logic rd, input logic wr,
                                     input logic [ADR_W-1:0] adr);
        return (rd ^ wr) && (wr == cur.rw) && (adr == cur.adr);
    endfunction

endpackage

// File: rtl/sysbus_master.sv
// Converts single-cycle read/write requests into held strobe/ack system bus cycles,
// returning read data with a done pulse and aborting hung cycles after TIMEOUT strobe cycles.
module sysbus_master
    import sysbus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [ADR_W-1:0]    address,
    input  logic [DAT_W-1:0]    wr_data,
    output logic                xfer_rdy,
    output logic                xfer_done,
    output logic [DAT_W-1:0]    rd_data,
    output logic                xfer_err,
    output logic                collision,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                sb_stb,
    output logic                sb_rw,
    output logic [ADR_W-1:0]    sb_adr,
    output logic [DAT_W-1:0]    sb_dat_o,
    input  logic [DAT_W-1:0]    sb_dat_i,
    input  logic                sb_ack
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("sysbus_master: TIMEOUT must be in 2..255");
    end

    state_t              state_q, state_d;
    sb_req_t             req_q, req_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DAT_W-1:0]    rd_data_q, rd_data_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                xfer_done_q, xfer_done_d;
    logic                xfer_err_q, xfer_err_d;
    logic                collision_q, collision_d;
    logic                xfer_rdy_q, xfer_rdy_d;
    logic                sb_stb_q, sb_stb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= REQ_RST;
            to_cnt_q    <= '0;
            rd_data_q   <= '0;
            err_count_q <= '0;
            xfer_done_q <= 1'b0;
            xfer_err_q  <= 1'b0;
            collision_q <= 1'b0;
            xfer_rdy_q  <= 1'b1;
            sb_stb_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            to_cnt_q    <= to_cnt_d;
            rd_data_q   <= rd_data_d;
            err_count_q <= err_count_d;
            xfer_done_q <= xfer_done_d;
            xfer_err_q  <= xfer_err_d;
            collision_q <= collision_d;
            xfer_rdy_q  <= xfer_rdy_d;
            sb_stb_q    <= sb_stb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        to_cnt_d    = to_cnt_q;
        rd_data_d   = rd_data_q;
        err_count_d = err_count_q;
        xfer_done_d = 1'b0;
        xfer_err_d  = 1'b0;
        collision_d = collision_q;

        unique case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d  = BUSY;
                    req_d    = '{rw: wr_en, adr: address, dat: wr_data};
                    to_cnt_d = '0;
                    if (rd_en && wr_en) begin
                        collision_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if ((rd_en || wr_en) && !is_hold(req_q, rd_en, wr_en, address)) begin
                    collision_d = 1'b1;
                end
                // Ack wins over a timeout landing in the same cycle.
                if (sb_ack) begin
                    state_d     = IDLE;
                    xfer_done_d = 1'b1;
                    if (!req_q.rw) begin
                        rd_data_d = sb_dat_i;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    xfer_done_d = 1'b1;
                    xfer_err_d  = 1'b1;
                    if (!req_q.rw) begin
                        rd_data_d = '0;
                    end
                    if (err_count_q != {ERRCNT_W{1'b1}}) begin
                        err_count_d = err_count_q + ERRCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        xfer_rdy_d = (state_d == IDLE);
        sb_stb_d   = (state_d == BUSY);
    end

    assign xfer_rdy  = xfer_rdy_q;
    assign xfer_done = xfer_done_q;
    assign xfer_err  = xfer_err_q;
    assign rd_data   = rd_data_q;
    assign collision = collision_q;
    assign err_count = err_count_q;
    assign sb_stb    = sb_stb_q;
    assign sb_rw     = req_q.rw;
    assign sb_adr    = req_q.adr;
    assign sb_dat_o  = req_q.dat;

endmodule

// File: doc/sysbus_master.md
# sysbus_master

Bridge between the system SPI subordinate state machine and the SPI hard IP system bus (SB_SPI `SBSTBi`, `SBRWi`, `SBADRi`, `SBDATi`, `SBDATO`, `SBACKO`).
- Turns single-cycle `rd_en`/`wr_en` requests into held strobe/ack bus cycles.
- Returns read data with a one-cycle `xfer_done` pulse.
- Advertises readiness on `xfer_rdy`.
- Aborts hung bus cycles with a timeout.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles to wait for `sb_ack` before aborting; legal range 2..255.
- `ERRCNT_W`, 8: width of the saturating error counter.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_en` in 1: read request, sampled only in IDLE.
- `wr_en` in 1: write request, sampled only in IDLE.
- `address` in 8: system bus register address (SPITXDR 0x59, SPIISR 0x5A, SPIRXDR 0x5B).
- `wr_data` in 8: write data.
- `xfer_rdy` out 1: bridge is idle and will accept a request this cycle.
- `xfer_done` out 1: one-cycle pulse when a transfer completes or aborts.
- `rd_data` out 8: read result; holds its value until the next read completes.
- `xfer_err` out 1: qualifies `xfer_done`; high means the cycle was aborted by timeout.
- `collision` out 1: sticky; set by an illegal request (see Operation).
- `err_count` out `ERRCNT_W`: saturating count of timeouts.
- `sb_stb` out 1: bus strobe.
- `sb_rw` out 1: 1 = write, 0 = read.
- `sb_adr` out 8: bus address.
- `sb_dat_o` out 8: data to the IP.
- `sb_dat_i` in 8: data from the IP.
- `sb_ack` in 1: IP acknowledge.

## Operation
- There are two states.
  - IDLE: `xfer_rdy`=1, `sb_stb`=0.
  - BUSY: `xfer_rdy`=0, `sb_stb`=1.
- IDLE → BUSY when `rd_en|wr_en`.
  - `address` and `wr_data` are latched, and direction is latched into `sb_rw`.
  - If both enables are high, the cycle is a write and `collision` is set.
- `sb_adr`, `sb_dat_o` and `sb_rw` are registered and stay constant for the whole BUSY period.
- BUSY → IDLE on `sb_ack`=1:
  - pulse `xfer_done`=1 with `xfer_err`=0;
  - on a read, latch `rd_data` ← `sb_dat_i`;
  - on a write, leave `rd_data` unchanged.
- BUSY → IDLE when the timeout counter reaches `TIMEOUT-1` with no ack:
  - pulse `xfer_done`=1 with `xfer_err`=1;
  - `err_count` increments and saturates at all-ones;
  - on a read, `rd_data` ← 0x00, so ISR ready bits read as not-ready and the upstream FSM does not advance on garbage.
- Requests in BUSY:
  - A request whose address and direction match the in-flight cycle is a hold and is ignored silently. This is the upstream write-retry pattern.
  - Any other request in BUSY is dropped and sets `collision`.
- `collision` clears only on reset.
- The timeout counter clears on entry to BUSY and counts while in BUSY.
- `sb_ack` is ignored in IDLE.
- Reset values: state IDLE, `xfer_rdy`=1, `xfer_done`=0, `xfer_err`=0, `rd_data`=0x00, `collision`=0, `err_count`=0, `sb_stb`=0, `sb_rw`=0, `sb_adr`=0x59, `sb_dat_o`=0x00.
- Reset mid-transfer drops `sb_stb` immediately (asynchronous) and produces no `xfer_done`.

## Timing
- Request sampled at edge N: `sb_stb` is high from N+1.
- Ack sampled at edge M:
  - `sb_stb`=0 from M+1;
  - `xfer_done`, `xfer_err` and `rd_data` are valid in cycle M+1;
  - `xfer_rdy`=1 in cycle M+1.
- A request presented in cycle M+1 is accepted, giving back-to-back transfers. `sb_stb` is low for exactly one cycle between them, as the IP requires.
- Minimum transfer: request to done is 2 cycles, with ack in the first strobe cycle.
- Timeout: `sb_stb` high for exactly `TIMEOUT` cycles, then done/err in the next cycle.
- `xfer_done` is never high for two consecutive cycles.
- All outputs are registered; there are no combinational paths from the SB inputs to the upstream outputs.

## Structure
- Shared package `sysbus_pkg` holds:
  - state enum (IDLE, BUSY);
  - SB register address constants SPITXDR 0x59, SPIISR 0x5A, SPIRXDR 0x5B;
  - ISR bit indices RRDY=3, TRDY=4.
- The upstream subordinate FSM imports the same package.
- No sub-module; the timeout counter is inline.

## Test plan
- Read 0x5A with `sb_ack` one cycle after strobe and `sb_dat_i`=0x18 → `rd_data`=0x18, `xfer_done` one cycle, `xfer_err`=0, `sb_adr` stable at 0x5A.
- Write 0xA5 to 0x59 with `wr_en` held high for 5 cycles and ack on the 4th strobe cycle → exactly one bus cycle, `sb_dat_o`=0xA5, `collision`=0, `rd_data` unchanged.
- Back-to-back: read 0x5B, then a request in the done cycle → `sb_stb` low for exactly 1 cycle between the two strobes.
- No ack, `TIMEOUT`=64 → strobe high for 64 cycles, then `xfer_done`=`xfer_err`=1, `rd_data`=0x00, `err_count`=1. After 260 such timeouts, `err_count`=255.
- `rd_en` and `wr_en` both high in IDLE → write cycle, `collision`=1. A different-address request during BUSY is dropped and `collision` stays 1.
- Assert `rst` during BUSY → `sb_stb`=0 asynchronously, no `xfer_done`, all outputs at their reset values; the next request completes normally.
